// File: rtl/sprite_line_engine.sv
// Per-scanline sprite pixel engine: N_SPR loadable slots with X delay, pattern shift,
// lowest-index-wins priority, sprite-0 hit and load overflow reporting.
module sprite_line_engine #(
    parameter int unsigned N_SPR = 8,
    parameter int unsigned BPP   = 2,
    parameter int unsigned XW    = 8,
    parameter int unsigned PALW  = 2,
    parameter int unsigned CW    = $clog2(N_SPR + 1)
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic              i_line_start,
    input  logic              i_enable,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [8*BPP-1:0]  i_load_pattern,
    input  logic [XW-1:0]     i_load_x,
    input  logic [PALW-1:0]   i_load_pal,
    input  logic              i_load_prio,
    input  logic              i_load_hflip,
    input  logic              i_load_spr0,
    output logic [BPP-1:0]    o_pixel,
    output logic [PALW-1:0]   o_pal,
    output logic              o_prio,
    output logic              o_opaque,
    output logic              o_spr0_hit,
    output logic              o_spr0_seen,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_overflow
);

    logic [BPP-1:0][7:0] pat_q  [N_SPR];
    logic [XW-1:0]       x_q    [N_SPR];
    logic [PALW-1:0]     pal_q  [N_SPR];
    logic [N_SPR-1:0]    valid_q;
    logic [N_SPR-1:0]    prio_q;
    logic [N_SPR-1:0]    spr0_q;

    logic                full;
    logic                load_fire;
    logic [CW-1:0]       load_idx;
    logic [BPP-1:0][7:0] pattern_in;
    logic [BPP-1:0]      win_pix;
    logic [PALW-1:0]     win_pal;
    logic                win_prio;
    logic                spr0_hit;

    assign full         = (o_count == CW'(N_SPR));
    assign o_full       = full;
    assign o_load_ready = ~full;
    // line start clears first, so a same-cycle load always lands in slot 0
    assign load_fire    = i_ce & i_load_valid & (i_line_start | ~full);
    assign load_idx     = i_line_start ? '0 : o_count;

    always_comb begin
        pattern_in = '0;
        for (int p = 0; p < int'(BPP); p++) begin
            for (int b = 0; b < 8; b++) begin
                pattern_in[p][b] = i_load_hflip ? i_load_pattern[8*p + 7 - b]
                                                : i_load_pattern[8*p + b];
            end
        end
    end

    // Scan from the highest index down so the lowest opaque slot wins.
    always_comb begin
        logic [BPP-1:0] slot_pix;
        slot_pix = '0;
        win_pix  = '0;
        win_pal  = '0;
        win_prio = 1'b0;
        spr0_hit = 1'b0;
        for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
            for (int p = 0; p < int'(BPP); p++) begin
                slot_pix[p] = pat_q[i][p][7];
            end
            if (!valid_q[i] || (x_q[i] != '0)) begin
                slot_pix = '0;
            end
            if (slot_pix != '0) begin
                win_pix  = slot_pix;
                win_pal  = pal_q[i];
                win_prio = prio_q[i];
                if (spr0_q[i]) begin
                    spr0_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N_SPR); i++) begin
                pat_q[i] <= '0;
                x_q[i]   <= '0;
                pal_q[i] <= '0;
            end
            valid_q     <= '0;
            prio_q      <= '0;
            spr0_q      <= '0;
            o_count     <= '0;
            o_overflow  <= 1'b0;
            o_spr0_seen <= 1'b0;
            o_pixel     <= '0;
            o_pal       <= '0;
            o_prio      <= 1'b0;
            o_opaque    <= 1'b0;
            o_spr0_hit  <= 1'b0;
        end else if (i_ce) begin
            for (int i = 0; i < int'(N_SPR); i++) begin
                if (i_line_start) begin
                    valid_q[i] <= 1'b0;
                end else if (i_enable && valid_q[i]) begin
                    if (x_q[i] != '0) begin
                        x_q[i] <= x_q[i] - XW'(1);
                    end else begin
                        for (int p = 0; p < int'(BPP); p++) begin
                            pat_q[i][p] <= {pat_q[i][p][6:0], 1'b0};
                        end
                    end
                end
                // the slot being loaded takes fresh values instead of shifting
                if (load_fire && (load_idx == CW'(i))) begin
                    pat_q[i]   <= pattern_in;
                    x_q[i]     <= i_load_x;
                    pal_q[i]   <= i_load_pal;
                    prio_q[i]  <= i_load_prio;
                    spr0_q[i]  <= i_load_spr0;
                    valid_q[i] <= 1'b1;
                end
            end

            if (load_fire) begin
                o_count <= load_idx + CW'(1);
            end else if (i_line_start) begin
                o_count <= '0;
            end

            if (i_line_start) begin
                o_overflow <= 1'b0;
            end else if (i_load_valid && full) begin
                o_overflow <= 1'b1;
            end

            if (i_line_start) begin
                o_spr0_seen <= 1'b0;
            end else if (i_enable && spr0_hit) begin
                o_spr0_seen <= 1'b1;
            end

            if (i_enable) begin
                o_pixel    <= win_pix;
                o_pal      <= win_pal;
                o_prio     <= win_prio;
                o_opaque   <= (win_pix != '0);
                o_spr0_hit <= spr0_hit;
            end else begin
                o_pixel    <= '0;
                o_opaque   <= 1'b0;
                o_spr0_hit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: directed steps plus random traffic against a
// per-slot "pixels since load" reference model.
module tb_sprite_line_engine;
    localparam int N    = 8;
    localparam int BPP  = 2;
    localparam int XW   = 8;
    localparam int PALW = 2;
    localparam int CW   = $clog2(N + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, ce, ls, en, lv, ld_prio, ld_hflip, ld_spr0;
    logic [8*BPP-1:0]  ld_pat;
    logic [XW-1:0]     ld_x;
    logic [PALW-1:0]   ld_pal;
    logic              load_ready, prio, opaque, spr0_hit, spr0_seen, full, overflow;
    logic [BPP-1:0]    pixel;
    logic [PALW-1:0]   pal;
    logic [CW-1:0]     count;

    sprite_line_engine #(.N_SPR(N), .BPP(BPP), .XW(XW), .PALW(PALW), .CW(CW)) dut (
        .clk(clk), .i_rst(rst), .i_ce(ce), .i_line_start(ls), .i_enable(en),
        .i_load_valid(lv), .o_load_ready(load_ready), .i_load_pattern(ld_pat),
        .i_load_x(ld_x), .i_load_pal(ld_pal), .i_load_prio(ld_prio),
        .i_load_hflip(ld_hflip), .i_load_spr0(ld_spr0), .o_pixel(pixel), .o_pal(pal),
        .o_prio(prio), .o_opaque(opaque), .o_spr0_hit(spr0_hit), .o_spr0_seen(spr0_seen),
        .o_count(count), .o_full(full), .o_overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // reference model: each slot remembers its stored pattern and how many enabled pixels elapsed
    bit             mv   [N];
    logic [7:0]     mp   [N][BPP];
    int             mx   [N];
    int             me   [N];
    logic [PALW-1:0] mpal [N];
    bit             mpr  [N];
    bit             ms0  [N];
    int             mcount;
    bit             mover, mseen, e_prio, e_opq, e_hit;
    logic [BPP-1:0] e_pix;
    logic [PALW-1:0] e_pal;

    function automatic logic [BPP-1:0] mpix(int i);
        logic [BPP-1:0] r;
        int j;
        r = '0;
        if (mv[i] && me[i] >= mx[i]) begin
            j = me[i] - mx[i];
            if (j < 8) for (int p = 0; p < BPP; p++) r[p] = mp[i][p][7 - j];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [BPP-1:0] wp, px;
        logic [PALW-1:0] wpal;
        bit wpr, hit, fire, isfull;
        int idx;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mv[i] = 0; mx[i] = 0; me[i] = 0; mpal[i] = '0; mpr[i] = 0; ms0[i] = 0;
                for (int p = 0; p < BPP; p++) mp[i][p] = '0;
            end
            mcount = 0; mover = 0; mseen = 0;
            e_pix = '0; e_pal = '0; e_prio = 0; e_opq = 0; e_hit = 0;
        end else if (ce) begin
            wp = '0; wpal = '0; wpr = 0; hit = 0;
            for (int i = 0; i < N; i++) begin
                px = mpix(i);
                if (px != 0 && wp == 0) begin wp = px; wpal = mpal[i]; wpr = mpr[i]; end
                if (px != 0 && ms0[i]) hit = 1;
            end
            isfull = (mcount == N);
            fire = lv && (ls || !isfull);
            if (lv && isfull && !ls) mover = 1;
            if (ls) begin
                for (int i = 0; i < N; i++) mv[i] = 0;
                mcount = 0; mover = 0; mseen = 0;
            end
            if (en) for (int i = 0; i < N; i++) if (mv[i]) me[i]++;
            if (fire) begin
                idx = mcount;
                mv[idx] = 1; me[idx] = 0; mx[idx] = int'(ld_x);
                mpal[idx] = ld_pal; mpr[idx] = ld_prio; ms0[idx] = ld_spr0;
                for (int p = 0; p < BPP; p++)
                    for (int b = 0; b < 8; b++)
                        mp[idx][p][b] = ld_hflip ? ld_pat[8*p + 7 - b] : ld_pat[8*p + b];
                mcount++;
            end
            if (en) begin
                e_pix = wp; e_pal = wpal; e_prio = wpr; e_opq = (wp != 0); e_hit = hit;
                if (hit && !ls) mseen = 1;
            end else begin
                e_pix = '0; e_opq = 0; e_hit = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("pixel", 32'(pixel), 32'(e_pix));
        chk("pal", 32'(pal), 32'(e_pal));
        chk("prio", 32'(prio), 32'(e_prio));
        chk("opaque", 32'(opaque), 32'(e_opq));
        chk("spr0_hit", 32'(spr0_hit), 32'(e_hit));
        chk("spr0_seen", 32'(spr0_seen), 32'(mseen));
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == N));
        chk("load_ready", 32'(load_ready), 32'(mcount != N));
        chk("overflow", 32'(overflow), 32'(mover));
    endtask

    task automatic load(input logic [15:0] pat, input int x, input int pl, input bit hf, input bit s0);
        lv = 1; ld_pat = pat; ld_x = XW'(x); ld_pal = PALW'(pl); ld_hflip = hf; ld_spr0 = s0;
        ld_prio = 0;
        tick();
        lv = 0; ld_hflip = 0; ld_spr0 = 0;
    endtask

    task automatic line_start();
        ls = 1; tick(); ls = 0;
    endtask

    initial begin
        rst = 1; ce = 1; ls = 0; en = 0; lv = 0; ld_prio = 0; ld_hflip = 0; ld_spr0 = 0;
        ld_pat = '0; ld_x = '0; ld_pal = '0;
        tick(); tick();
        rst = 0;
        repeat (4) tick();
        chk("idle_pixel", 32'(pixel), 32'd0);
        chk("idle_count", 32'(count), 32'd0);

        // single sprite, X=3: opaque on enabled pixels 4..7
        load(16'h00F0, 3, 0, 0, 0);
        en = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("x3_pix", 32'(pixel), (k >= 4 && k <= 7) ? 32'd1 : 32'd0);
        end
        en = 0;

        // same with hflip: opaque moves four pixels later
        line_start();
        load(16'h00F0, 3, 0, 1, 0);
        en = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("hflip_pix", 32'(pixel), (k >= 8 && k <= 11) ? 32'd1 : 32'd0);
        end
        en = 0;

        // priority overlap
        line_start();
        load(16'h000F, 0, 1, 0, 0);
        load(16'hFF00, 0, 2, 0, 0);
        en = 1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("prio_pix", 32'(pixel), (k <= 4) ? 32'd2 : 32'd1);
            chk("prio_pal", 32'(pal), (k <= 4) ? 32'd2 : 32'd1);
        end
        en = 0;

        // fill, overflow, then line start with a concurrent load
        line_start();
        for (int k = 0; k < N; k++) load(16'h0101, k, 0, 0, 0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(load_ready), 32'd0);
        load(16'hFFFF, 0, 3, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'(N));
        ls = 1; load(16'h00FF, 0, 1, 0, 0); ls = 0;
        chk("ls_load_count", 32'(count), 32'd1);
        chk("ls_load_ovf", 32'(overflow), 32'd0);

        // sprite 0 behind slot 0, then freeze with ce=0
        line_start();
        load(16'h00FF, 0, 1, 0, 0);
        load(16'hFF00, 0, 2, 0, 1);
        en = 1;
        tick();
        chk("s0_hit", 32'(spr0_hit), 32'd1);
        chk("s0_pix", 32'(pixel), 32'd1);
        ce = 0; ls = 1; lv = 1;
        repeat (3) tick();
        chk("freeze_seen", 32'(spr0_seen), 32'd1);
        chk("freeze_count", 32'(count), 32'd2);
        ce = 1; ls = 0; lv = 0; en = 0;
        repeat (3) tick();
        chk("s0_sticky", 32'(spr0_seen), 32'd1);
        line_start();
        chk("s0_cleared", 32'(spr0_seen), 32'd0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ce       = ($urandom_range(0, 3) != 0);
            ls       = ($urandom_range(0, 39) == 0);
            en       = ($urandom_range(0, 3) != 0);
            lv       = ($urandom_range(0, 2) == 0);
            ld_pat   = 16'($urandom);
            ld_x     = XW'($urandom_range(0, 12));
            ld_pal   = PALW'($urandom);
            ld_prio  = 1'($urandom);
            ld_hflip = 1'($urandom);
            ld_spr0  = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_line_engine.md
Name: sprite_line_engine

Overview:
- Parametrised per-scanline sprite pixel engine; successor to the fixed 8-slot sprite shift set.
- Holds up to N_SPR sprite slots with a configurable bit depth and optional horizontal flip. Slots are loaded through a valid/ready handshake.
- Each enabled pixel clock it outputs the highest-priority opaque sprite pixel, registered. It also reports sprite-0 hit and load overflow.
- Sits between the OAM evaluator/fetcher and the PPU pixel mux.

Parameters:
N_SPR, 8, number of sprite slots (1..64)
BPP, 2, bits per pixel (number of pattern planes)
XW, 8, width of the X-delay counter
PALW, 2, width of the palette-select field
CW, $clog2(N_SPR+1), width of the slot count

Ports:
clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_ce  in  1  clock enable; all state except reset changes only when i_ce=1
i_line_start  in  1  clears all slots, count and line flags
i_enable  in  1  pixel advance (visible pixel period)
i_load_valid  in  1  load request
o_load_ready  out  1  = !o_full
i_load_pattern  in  8*BPP  plane p in bits [8p+7:8p]; bit 7 is the leftmost pixel
i_load_x  in  XW  pixel delay before the sprite starts
i_load_pal  in  PALW  palette select
i_load_prio  in  1  behind-background flag
i_load_hflip  in  1  reverse pattern bit order at load
i_load_spr0  in  1  slot carries sprite 0
o_pixel  out  BPP  winning pixel index (0 = transparent)
o_pal  out  PALW  palette of the winner
o_prio  out  1  prio of the winner
o_opaque  out  1  o_pixel != 0
o_spr0_hit  out  1  a sprite-0 slot was opaque this pixel (any priority)
o_spr0_seen  out  1  sticky since i_line_start
o_count  out  CW  slots loaded this line
o_full  out  1  o_count == N_SPR
o_overflow  out  1  sticky: valid seen while full; cleared by i_line_start

Behaviour:
- Reset:
  - All slots invalid; patterns, X, pal, prio and spr0 = 0.
  - o_count=0, o_full=0, o_load_ready=1, o_overflow=0, o_spr0_seen=0.
  - All pixel outputs = 0.
  - Reset overrides every other input.
- Load transfer = i_ce & i_load_valid & o_load_ready.
  - Writes slot[o_count] and marks it valid; o_count increments.
  - With i_load_hflip=1, each plane is bit-reversed before storage.
- i_line_start (with i_ce) applies clear-then-load:
  - Invalidates all slots and zeroes o_count, o_overflow, o_spr0_seen.
  - A load asserted in the same cycle is accepted into slot 0; o_count becomes 1.
- i_load_valid while o_full (and i_ce) sets o_overflow; no slot is altered.
- Slot advance (i_ce & i_enable, valid slots not loaded this cycle):
  - If X != 0: X decrements.
  - Else: each plane shifts left by 1, filling with 0.
  - The slot being loaded in that cycle takes the new values and does not shift.
  - Slots are active when X == 0. After 8 shifts the pattern is 0 and the slot is transparent.
  - X decrement saturates at 0; there is no wrap.
- Slot pixel = {plane[BPP-1][7], …, plane[0][7]} when valid & active, else 0.
- Winner = lowest-index slot with a nonzero pixel.
- Output register (updates on i_ce):
  - If i_enable=1: o_pixel, o_pal, o_prio and o_opaque take the winner's values, computed from the pre-advance state.
  - If no opaque slot: o_pixel=0, o_opaque=0, o_pal=0, o_prio=0.
  - If i_enable=0: o_pixel=0, o_opaque=0, o_spr0_hit=0; o_pal and o_prio hold.
  - Latency: one clk from the enabled pixel to its output.
- o_spr0_hit = any valid spr0-flagged slot with a nonzero pixel (pre-advance), registered alongside o_pixel.
  - o_spr0_seen sets with it and is sticky.
- i_ce=0: nothing changes; inputs are ignored, including i_line_start and the load handshake.
- Arithmetic: X compare and decrement are XW bits; o_count saturates at N_SPR.

Test Plan:
- Reset, then idle for 4 cycles -> o_pixel=0, o_count=0, o_load_ready=1, o_overflow=0.
- Load slot0 with pattern plane0=8'hF0, plane1=8'h00, X=3, then 12 enabled cycles -> o_pixel=1 on output cycles 5..8 (pixels 4..7 after the 1-cycle latency), 0 otherwise.
- Same as the previous test with hflip=1 -> opaque output begins 4 pixels later: outputs 9..12.
- Priority overlap:
  - Setup: slot0 plane0=8'h0F, pal=1; slot1 plane1=8'hFF, pal=2; both X=0.
  - First 4 outputs: pixel=2, pal=2.
  - Next 4 outputs: pixel=1, pal=1.
- Overflow (N_SPR=8):
  - Load 8 slots -> o_full=1, o_load_ready=0.
  - Ninth valid -> o_overflow=1, count stays 8.
  - i_line_start together with a valid load -> count=1, overflow=0.
- Sprite 0 behind another sprite:
  - Setup: slot1 spr0=1 overlaps opaque slot0.
  - Response: o_spr0_hit=1 while o_pixel comes from slot0; o_spr0_seen stays 1 until i_line_start.
  - Toggle i_ce=0 mid-line -> outputs and state freeze.
